// File: rtl/irda_int_dma_ctrl_if.sv
// DMA handshake bundle for irda_int_dma_ctrl: enable, and request/acknowledge
// pairs for the RX and TX channels.
interface irda_int_dma_ctrl_if;
    logic use_dma_i;
    logic dma_req_r_o;
    logic dma_ack_r_i;
    logic dma_req_t_o;
    logic dma_ack_t_i;

    // master: system DMA / register-file side; slave: the controller.
    modport master (
        output use_dma_i, dma_ack_r_i, dma_ack_t_i,
        input  dma_req_r_o, dma_req_t_o
    );
    modport slave (
        input  use_dma_i, dma_ack_r_i, dma_ack_t_i,
        output dma_req_r_o, dma_req_t_o
    );
endinterface

// File: rtl/irda_int_dma_ctrl.sv
// IrDA interrupt, status and burst DMA-request controller.
// Define IRDA_RX_TIMEOUT_EN to build the RX idle-timeout source (status bit 2).
module irda_int_dma_ctrl #(
    parameter int FIFO_PTR_W = 4,
    parameter int N_EVT      = 5,
    parameter int DMA_BURST  = 4,
    parameter int TO_CYCLES  = 64
) (
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic [FIFO_PTR_W:0]   rx_count_i,
    input  logic [FIFO_PTR_W:0]   tx_count_i,
    input  logic [FIFO_PTR_W:0]   rx_level_i,
    input  logic [FIFO_PTR_W:0]   tx_level_i,
    input  logic                  rx_push_i,
    input  logic                  rx_pop_i,
    input  logic [N_EVT-1:0]      evt_i,
    input  logic                  busy_i,
    input  logic [N_EVT+2:0]      ier_i,
    input  logic                  u_int_i,
    input  logic                  stat_rd_i,
    output logic [N_EVT+3:0]      stat_o,
    output logic                  int_o,
    irda_int_dma_ctrl_if.slave    dma
);

    localparam int               CW          = FIFO_PTR_W + 1;
    localparam logic [CW-1:0]    DEPTH       = CW'(2**FIFO_PTR_W);
    localparam logic [CW-1:0]    BURST       = CW'(DMA_BURST);
    // TX free space >= burst, rewritten so the subtraction is on constants.
    localparam logic [CW-1:0]    TX_MAX_FILL = DEPTH - BURST;
    localparam int               BW          = $clog2(DMA_BURST + 1);
    localparam logic [BW-1:0]    BEAT_LAST   = BW'(DMA_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } dma_state_e;

    logic rx_lvl;
    logic tx_lvl;
    logic to_fire;

    assign rx_lvl = rx_count_i >= rx_level_i;
    assign tx_lvl = tx_count_i <= tx_level_i;

`ifdef IRDA_RX_TIMEOUT_EN
    localparam int            TW      = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);
    localparam logic [TW-1:0] TO_HOLD = TW'(TO_CYCLES);

    logic [TW-1:0] to_cnt_q;
    logic          to_fire_q;
    logic          to_qual;

    assign to_qual = (rx_count_i != '0) && (rx_count_i < rx_level_i) &&
                     !rx_push_i && !rx_pop_i;

    // Parking at TO_HOLD makes the pulse one-shot per idle period.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            to_cnt_q  <= '0;
            to_fire_q <= 1'b0;
        end else begin
            to_fire_q <= 1'b0;
            if (!to_qual) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q == TO_LAST) begin
                to_cnt_q  <= TO_HOLD;
                to_fire_q <= 1'b1;
            end else if (to_cnt_q != TO_HOLD) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    assign to_fire = to_fire_q;
`else
    logic unused_rx_strobes;

    assign unused_rx_strobes = rx_push_i ^ rx_pop_i;
    assign to_fire           = 1'b0;
`endif

    logic [N_EVT+3:0] stat_q;
    logic [N_EVT+3:0] stat_d;
    logic [N_EVT+2:0] cond;
    logic [N_EVT+2:0] prev_q;
    logic [N_EVT+2:0] rise;
    logic             int_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        stat_d              = '0;
        stat_d[0]           = rx_lvl;
        stat_d[1]           = tx_lvl;
        stat_d[2]           = to_fire | (stat_q[2] & ~stat_rd_i);
        stat_d[N_EVT+2:3]   = evt_i | (stat_q[N_EVT+2:3] & {N_EVT{~stat_rd_i}});
        stat_d[N_EVT+3]     = busy_i;
    end

    assign cond = {evt_i, to_fire, tx_lvl, rx_lvl};
    assign rise = cond & ~prev_q;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            stat_q <= '0;
            prev_q <= '0;
            int_q  <= 1'b0;
        end else begin
            stat_q <= stat_d;
            prev_q <= cond;
            int_q  <= u_int_i | (|(ier_i & rise));
        end
    end

    assign stat_o = stat_q;
    assign int_o  = int_q;

    // Channel 0 = RX, channel 1 = TX.
    dma_state_e    state_q [2];
    dma_state_e    state_d [2];
    logic [BW-1:0] beat_q  [2];
    logic [BW-1:0] beat_d  [2];
    logic [1:0]    start;
    logic [1:0]    ack;

    assign start[0] = rx_lvl && (rx_count_i >= BURST);
    assign start[1] = tx_lvl && (tx_count_i <= TX_MAX_FILL);
    assign ack      = {dma.dma_ack_t_i, dma.dma_ack_r_i};

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= IDLE;
                beat_q[ch]  <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                beat_q[ch]  <= beat_d[ch];
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            beat_d[ch]  = beat_q[ch];
            if (!dma.use_dma_i) begin
                state_d[ch] = IDLE;
                beat_d[ch]  = '0;
            end else begin
                case (state_q[ch])
                    IDLE: begin
                        if (start[ch]) begin
                            state_d[ch] = REQ;
                        end
                    end
                    REQ: begin
                        if (ack[ch]) begin
                            if (beat_q[ch] == BEAT_LAST) begin
                                state_d[ch] = GAP;
                                beat_d[ch]  = '0;
                            end else begin
                                beat_d[ch] = beat_q[ch] + 1'b1;
                            end
                        end
                    end
                    // GAP guarantees one idle cycle before the next request.
                    GAP: begin
                        state_d[ch] = IDLE;
                    end
                    default: begin
                        state_d[ch] = IDLE;
                        beat_d[ch]  = '0;
                    end
                endcase
            end
        end
    end

    assign dma.dma_req_r_o = (state_q[0] == REQ);
    assign dma.dma_req_t_o = (state_q[1] == REQ);

endmodule
